// File: rtl/reg_file_16x16_if.sv
// Register-file bus: write-back port, two read ports and the issue/scoreboard signals.
// clk and rst_n stay plain ports on the register file.
interface reg_file_16x16_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              hazard_a;
  logic              hazard_b;
  logic [CNT_W-1:0]  pend_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, iss_valid, iss_addr,
    input  rd_data_a, rd_data_b, hazard_a, hazard_b, pend_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, iss_valid, iss_addr,
    output rd_data_a, rd_data_b, hazard_a, hazard_b, pend_cnt
  );
endinterface

// File: rtl/reg_file_16x16.sv
// 16x16 register file: 2 combinational reads, 1 sync write, pending-write scoreboard.
// Optional write-through bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file_16x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NREG   = 2**ADDR_W
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_16x16_if.slave bus
);
  localparam int CNT_W = 5;

  logic [NREG-1:0][DATA_W-1:0] r_regs;
  logic [NREG-1:0]             r_pend;
  logic [CNT_W-1:0]            r_pend_cnt;
  logic [NREG-1:0]             w_pend_nxt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic                        w_wr_hit;

  assign w_wr_hit = bus.wr_en && (bus.wr_addr != '0);

  // Issue is applied after retire so a same-cycle set/clear leaves the bit set.
  always_comb begin
    w_pend_nxt = r_pend;
    w_cnt_nxt  = '0;
    for (int i = 1; i < NREG; i++) begin
      if (bus.wr_en && bus.wr_addr == ADDR_W'(i))     w_pend_nxt[i] = 1'b0;
      if (bus.iss_valid && bus.iss_addr == ADDR_W'(i)) w_pend_nxt[i] = 1'b1;
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pend_nxt[i]);
    end
    w_pend_nxt[0] = 1'b0;
  end

  // r_regs[0] is never written, so R0 reads as zero through the normal mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs     <= '0;
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr_hit) r_regs[bus.wr_addr] <= bus.wr_data;
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp_a, w_byp_b;
  assign w_byp_a = w_wr_hit && (bus.rd_addr_a == bus.wr_addr);
  assign w_byp_b = w_wr_hit && (bus.rd_addr_b == bus.wr_addr);

  assign bus.rd_data_a = w_byp_a ? bus.wr_data : r_regs[bus.rd_addr_a];
  assign bus.rd_data_b = w_byp_b ? bus.wr_data : r_regs[bus.rd_addr_b];
  assign bus.hazard_a  = r_pend[bus.rd_addr_a] & ~w_byp_a;
  assign bus.hazard_b  = r_pend[bus.rd_addr_b] & ~w_byp_b;
`else
  assign bus.rd_data_a = r_regs[bus.rd_addr_a];
  assign bus.rd_data_b = r_regs[bus.rd_addr_b];
  assign bus.hazard_a  = r_pend[bus.rd_addr_a];
  assign bus.hazard_b  = r_pend[bus.rd_addr_b];
`endif

  assign bus.pend_cnt = r_pend_cnt;
endmodule

// File: tb/tb_reg_file_16x16.sv
// Bench for reg_file_16x16: vector table, corner sequences, random run vs. array model.
module tb_reg_file_16x16;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_16x16_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(5)) bus ();
  reg_file_16x16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        iv;
    logic [3:0]  ia;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_ha;
    logic        exp_hb;
    logic [4:0]  exp_cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_reg [16];
  bit          m_pend[16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic we, logic [3:0] wa, logic [15:0] wd, logic [3:0] ra,
                       logic [3:0] rb, logic iv, logic [3:0] ia);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_addr_a = ra; bus.rd_addr_b = rb;
    bus.iss_valid = iv; bus.iss_addr = ia;
  endtask

  function automatic bit byp_hit(logic [3:0] ra);
`ifdef REGFILE_BYPASS_EN
    return bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == ra;
`else
    return (ra == 4'd0) && (ra != 4'd0);
`endif
  endfunction

  function automatic logic [15:0] exp_rd(logic [3:0] ra);
    if (ra == 0) return 16'h0000;
    if (byp_hit(ra)) return bus.wr_data;
    return m_reg[ra];
  endfunction

  function automatic logic exp_hz(logic [3:0] ra);
    if (byp_hit(ra)) return 1'b0;
    return m_pend[ra];
  endfunction

  function automatic logic [4:0] exp_cnt();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_pend[i]);
    return 5'(c);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin m_reg[i] = 16'h0; m_pend[i] = 1'b0; end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".rd_a"}, 32'(bus.rd_data_a), 32'(exp_rd(bus.rd_addr_a)));
    chk({tag, ".rd_b"}, 32'(bus.rd_data_b), 32'(exp_rd(bus.rd_addr_b)));
    chk({tag, ".hz_a"}, 32'(bus.hazard_a), 32'(exp_hz(bus.rd_addr_a)));
    chk({tag, ".hz_b"}, 32'(bus.hazard_b), 32'(exp_hz(bus.rd_addr_b)));
    chk({tag, ".cnt"},  32'(bus.pend_cnt), 32'(exp_cnt()));
  endtask

  // Model update uses the architectural rules: retire, then issue, R0 untouched.
  task automatic tick();
    @(posedge clk);
    if (bus.wr_en && bus.wr_addr != 0) begin
      m_reg[bus.wr_addr]  = bus.wr_data;
      m_pend[bus.wr_addr] = 1'b0;
    end
    if (bus.iss_valid && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1'b1;
    #1;
  endtask

  vec_t tv[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{1, 0, 16'hFFFF, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 0};
    tv[1]  = '{0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0};
    tv[2]  = '{1, 7, 16'hA5A5, 1, 2, 0, 0, 16'h0,    16'h0,    0, 0, 0};
    tv[3]  = '{0, 0, 16'h0,    7, 7, 0, 0, 16'hA5A5, 16'hA5A5, 0, 0, 0};
    tv[4]  = '{0, 0, 16'h0,    4, 7, 1, 4, 16'h0,    16'hA5A5, 0, 0, 0};
    tv[5]  = '{0, 0, 16'h0,    4, 4, 0, 0, 16'h0,    16'h0,    1, 1, 1};
    tv[6]  = '{1, 4, 16'h4444, 7, 7, 0, 0, 16'hA5A5, 16'hA5A5, 0, 0, 1};
    tv[7]  = '{0, 0, 16'h0,    4, 0, 0, 0, 16'h4444, 16'h0,    0, 0, 0};
    tv[8]  = '{0, 0, 16'h0,    9, 9, 1, 9, 16'h0,    16'h0,    0, 0, 0};
    tv[9]  = '{1, 9, 16'h9999, 4, 0, 1, 9, 16'h4444, 16'h0,    0, 0, 1};
    tv[10] = '{0, 0, 16'h0,    9, 9, 0, 0, 16'h9999, 16'h9999, 1, 1, 1};

    m_clear();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_model("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].ra, tv[i].rb, tv[i].iv, tv[i].ia);
      @(negedge clk);
      chk($sformatf("tv%0d.rd_a", i), 32'(bus.rd_data_a), 32'(tv[i].exp_a));
      chk($sformatf("tv%0d.rd_b", i), 32'(bus.rd_data_b), 32'(tv[i].exp_b));
      chk($sformatf("tv%0d.hz_a", i), 32'(bus.hazard_a),  32'(tv[i].exp_ha));
      chk($sformatf("tv%0d.hz_b", i), 32'(bus.hazard_b),  32'(tv[i].exp_hb));
      chk($sformatf("tv%0d.cnt", i),  32'(bus.pend_cnt),  32'(tv[i].exp_cnt));
      tick();
    end

    // Write-then-read latency on R3
    drive(1, 3, 16'h1111, 0, 0, 0, 0); @(negedge clk); tick();
    drive(1, 3, 16'h1234, 3, 0, 0, 0); @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("lat_edge", 32'(bus.rd_data_a), 32'h1234);
`else
    chk("lat_edge", 32'(bus.rd_data_a), 32'h1111);
`endif
    tick();
    drive(0, 0, 0, 3, 0, 0, 0); @(negedge clk);
    chk("lat_next", 32'(bus.rd_data_a), 32'h1234);
    tick();

    // Issue R1..R15: count must reach 15 and stay there
    for (int a = 1; a < 16; a++) begin
      drive(0, 0, 0, 4'(a), 0, 1, 4'(a)); @(negedge clk);
      chk_model($sformatf("sat%0d", a)); tick();
    end
    drive(0, 0, 0, 5, 9, 1, 5); @(negedge clk);
    chk("sat_full", 32'(bus.pend_cnt), 32'd15);
    chk("sat_hz", 32'(bus.hazard_a), 32'd1);
    tick();
    drive(0, 0, 0, 5, 9, 0, 0); @(negedge clk);
    chk("sat_nowrap", 32'(bus.pend_cnt), 32'd15);
    tick();

    // Async reset mid-cycle after writing BEEF to R5
    drive(1, 5, 16'hBEEF, 5, 5, 0, 0); @(negedge clk); tick();
    drive(0, 0, 0, 5, 5, 0, 0);
    #2;
    chk("pre_rst", 32'(bus.rd_data_a), 32'hBEEF);
    rst_n = 1'b0; m_clear();
    #1;
    chk("rst_rd", 32'(bus.rd_data_a), 32'h0);
    chk("rst_hz", 32'(bus.hazard_b), 32'h0);
    chk("rst_cnt", 32'(bus.pend_cnt), 32'h0);
    // A write spanning the reset edge must be discarded
    drive(1, 6, 16'h6666, 6, 0, 1, 6);
    @(posedge clk); #1;
    drive(0, 0, 0, 6, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_discard", 32'(bus.rd_data_a), 32'h0);
    chk("rst_discard_cnt", 32'(bus.pend_cnt), 32'h0);
    tick();

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 4'($urandom),
            4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
      @(negedge clk);
      chk_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry × 16-bit general-purpose register file for the 16-bit RISC core.
- Sits directly downstream of the 4-bit 2:1 destination-select mux. That mux output drives wr_addr here; sel chooses between the rd and rt instruction fields.
- Provides two combinational read ports, one synchronous write port, and a per-register pending-write scoreboard. Decode uses the scoreboard for hazard stalls.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width; must match the destination-select mux width.
- NREG, 16, number of registers; fixed at 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write-back enable.
- wr_addr  input  ADDR_W  write-back destination, from the destination-select mux.
- wr_data  input  DATA_W  write-back data.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.
- iss_valid  input  1  an instruction with a register destination issued this cycle.
- iss_addr  input  ADDR_W  destination of the issued instruction.
- hazard_a  output  1  rd_addr_a has a pending write.
- hazard_b  output  1  rd_addr_b has a pending write.
- pend_cnt  output  5  number of registers currently pending (0..15).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 16 registers clear to 0x0000.
  - All pending bits clear; pend_cnt = 0.
  - Because reads and hazards are combinational, rd_data_a/b = 0x0000 and hazard_a/b = 0 while reset is held.
  - Reset asserted mid-write discards that write.
- Register R0:
  - Hardwired zero; always reads 0x0000.
  - Writes to address 0 are ignored.
  - R0 is never marked pending; iss_addr = 0 is ignored.
- Write:
  - When wr_en = 1 and wr_addr ≠ 0, wr_data is stored on the rising edge.
  - The new value is visible on the read ports from the next cycle (without the optional feature).
- Read:
  - Combinational, zero latency: rd_data_x = reg[rd_addr_x].
  - Both ports may address the same register.
- Scoreboard: pend[i] is updated each rising edge as follows.
  - Clear when wr_en = 1 and wr_addr = i (i ≠ 0).
  - Set when iss_valid = 1 and iss_addr = i (i ≠ 0).
  - Same register set and cleared in one cycle: set wins. The write retires the older producer; the newly issued instruction is now pending.
  - Set on an already-pending register: stays 1. No counting per register.
  - Clear on a non-pending register: no effect, no error.
- Hazard outputs:
  - hazard_x = pend[rd_addr_x], combinational from current state.
  - Without the optional feature, a write in progress does not suppress hazard in the same cycle.
- pend_cnt:
  - Registered population count of pend[15:1].
  - Updated on the same edge as pend.
  - Range 0..15; never wraps.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass: if wr_en = 1, wr_addr ≠ 0 and rd_addr_x = wr_addr, then rd_data_x = wr_data in the same cycle.
  - hazard_x is forced 0 for that port in that cycle, since the pending value is being delivered now.
  - Never bypasses for address 0.
- Undefined:
  - No bypass; a read of the register being written returns the old value until the next cycle.
  - hazard_x follows pend only.

Test Plan:
- Reset clears state: write 0xBEEF to R5, pulse rst_n low asynchronously mid-cycle → rd_data_a at addr 5 = 0x0000 immediately; pend_cnt = 0.
- R0 protection: wr_en = 1, wr_addr = 0, wr_data = 0xFFFF; iss_valid = 1, iss_addr = 0 → rd_data at addr 0 = 0x0000; pend_cnt stays 0.
- Write-then-read latency: write 0x1234 to R3 at edge N with rd_addr_a = 3 → without bypass, rd_data_a = old value in cycle N and 0x1234 from N+1. With REGFILE_BYPASS_EN, 0x1234 in cycle N.
- Dual-port same address: R7 = 0xA5A5, rd_addr_a = rd_addr_b = 7 → both ports read 0xA5A5.
- Scoreboard set/clear:
  - Issue R4 → next cycle hazard_a = 1 (rd_addr_a = 4), pend_cnt = 1.
  - Write R4 → next cycle hazard_a = 0, pend_cnt = 0.
- Simultaneous set and clear: R9 pending; in one cycle write R9 and issue R9 → R9 stays pending, pend_cnt unchanged at 1, R9 holds the written data. Then issue R1..R15 → pend_cnt saturates at 15 with no wrap.
